// File: rtl/ctrl_fifo_pkg.sv
// ctrl_fifo_pkg: shared field widths, writer FSM states and entry packing
// for the command fifo between ctrl_fifo_writer and ctrl_top.
package ctrl_fifo_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WAIT_W  = 32;
  localparam int unsigned CTRL_W  = 8;
  localparam int unsigned ENTRY_W = CTRL_W + WAIT_W + ADDR_W;
  localparam int unsigned AXIS_W  = 32;

  typedef enum logic [2:0] {
    S_ADDR = 3'd0,
    S_WAIT = 3'd1,
    S_CTRL = 3'd2,
    S_PUSH = 3'd3,
    S_DROP = 3'd4
  } state_e;

  // Fifo entry layout: {ctrl, wait, addr}
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [CTRL_W-1:0] ctrl_v,
    input logic [WAIT_W-1:0] wait_v,
    input logic [ADDR_W-1:0] addr_v
  );
    return {ctrl_v, wait_v, addr_v};
  endfunction

endpackage

// File: rtl/ctrl_fifo_writer.sv
// ctrl_fifo_writer: assembles 3-beat AXIS command frames (addr, wait, ctrl)
// into 72-bit entries and pushes them into the command fifo.
// Optional macro CTRL_FIFO_WRITER_TLAST_CHECK_EN enables tlast framing checks
// (err_o pulse, resync via S_DROP); without it tlast is ignored and err_o = 0.
module ctrl_fifo_writer
  import ctrl_fifo_pkg::*;
#(
  parameter int unsigned B  = 72,
  parameter int unsigned BD = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BD-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  output logic          s_axis_tready,
  output logic          fifo_wr_en,
  output logic [B-1:0]  fifo_din,
  input  logic          fifo_full,
  output logic          busy_o,
  output logic          err_o,
  output logic [31:0]   push_cnt_o
);

  state_e              state_q;
  state_e              state_d;
  logic [ADDR_W-1:0]   addr_r;
  logic [WAIT_W-1:0]   wait_r;
  logic [CTRL_W-1:0]   ctrl_r;
  logic [31:0]         push_cnt_r;
  logic                beat;
  logic                frame_err;
  logic                load_addr;
  logic                load_wait;
  logic                load_ctrl;

  assign beat = s_axis_tvalid & s_axis_tready;

`ifdef CTRL_FIFO_WRITER_TLAST_CHECK_EN
  logic err_r;

  // tlast must appear on the ctrl beat and nowhere else in a frame
  assign frame_err = beat & (((state_q == S_ADDR) | (state_q == S_WAIT)) & s_axis_tlast
                           | ((state_q == S_CTRL) & ~s_axis_tlast));

  // One-cycle error pulse following the offending beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_r <= 1'b0;
    else     err_r <= frame_err;
  end

  assign err_o = err_r;
`else
  logic unused_tlast;

  assign unused_tlast = s_axis_tlast;
  assign frame_err    = 1'b0;
  assign err_o        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_ADDR;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ADDR:  if (beat) state_d = frame_err ? S_ADDR : S_WAIT;
      S_WAIT:  if (beat) state_d = frame_err ? S_ADDR : S_CTRL;
      S_CTRL:  if (beat) state_d = frame_err ? S_DROP : S_PUSH;
      S_PUSH:  if (!fifo_full) state_d = S_ADDR;
      S_DROP:  if (beat && s_axis_tlast) state_d = S_ADDR;
      default: state_d = S_ADDR;
    endcase
  end

  // Output decode: handshake, write strobe and field load enables
  always_comb begin
    s_axis_tready = 1'b0;
    fifo_wr_en    = 1'b0;
    load_addr     = 1'b0;
    load_wait     = 1'b0;
    load_ctrl     = 1'b0;
    case (state_q)
      S_ADDR: begin
        s_axis_tready = ~rst;
        load_addr     = s_axis_tvalid & ~rst;
      end
      S_WAIT: begin
        s_axis_tready = ~rst;
        load_wait     = s_axis_tvalid & ~rst;
      end
      S_CTRL: begin
        s_axis_tready = ~rst;
        load_ctrl     = s_axis_tvalid & ~rst;
      end
      S_PUSH:  fifo_wr_en    = ~fifo_full;
      S_DROP:  s_axis_tready = ~rst;
      default: s_axis_tready = 1'b0;
    endcase
  end

  // Field registers and write counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r     <= '0;
      wait_r     <= '0;
      ctrl_r     <= '0;
      push_cnt_r <= '0;
    end else begin
      if (load_addr)  addr_r     <= ADDR_W'(s_axis_tdata);
      if (load_wait)  wait_r     <= WAIT_W'(s_axis_tdata);
      if (load_ctrl)  ctrl_r     <= s_axis_tdata[CTRL_W-1:0];
      if (fifo_wr_en) push_cnt_r <= push_cnt_r + 32'd1;
    end
  end

  assign fifo_din   = B'(pack_entry(ctrl_r, wait_r, addr_r));
  assign busy_o     = (state_q != S_ADDR);
  assign push_cnt_o = push_cnt_r;

endmodule
